// File: rtl/cpu_pkg.sv
// Shared types and constants for the Falcon pipeline hazard/forwarding controller.
// Stage entry fields are sized for up to 32 registers and up to 7 forwarding stages.
package cpu_pkg;

   localparam int STAGE_REG_BITS = 5;
   localparam int STAGE_SEL_BITS = 3;

   localparam logic [STAGE_REG_BITS-1:0] REG_ZERO = '0;

   localparam logic [STAGE_SEL_BITS-1:0] AVAIL_ALU  = 3'd1;
   localparam logic [STAGE_SEL_BITS-1:0] AVAIL_LOAD = 3'd2;

   typedef logic [STAGE_SEL_BITS-1:0] bypass_sel_t;

   typedef struct packed {
      logic [STAGE_REG_BITS-1:0] reg_d;
      logic                      write_en;
      bypass_sel_t               avail_stage;
   } stage_entry_t;

   function automatic stage_entry_t nop_entry();
      stage_entry_t e;
      e             = '0;
      e.avail_stage = AVAIL_ALU;
      return e;
   endfunction

endpackage

// File: rtl/cpu_scoreboard.sv
// Busy-register scoreboard for the single outstanding multi-cycle (mul/div) op.
// Lookups already see a completing op as retired, so done-then-issue works in one cycle.
module cpu_scoreboard
   import cpu_pkg::*;
#(
   parameter int NUM_Q    = 3,
   parameter int REG_BITS = 5
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           set_en,
   input  logic [REG_BITS-1:0]            set_reg,
   input  logic                           done,
   input  logic [NUM_Q-1:0][REG_BITS-1:0] query_reg,
   output logic [NUM_Q-1:0]               query_busy,
   output logic                           long_busy
);

   localparam int NUM_REGS = 2 ** REG_BITS;

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_eff;
   logic [REG_BITS-1:0] long_reg_q;
   logic                retire;

   assign retire = done && long_busy;

   // NOTE: every variable driven here gets a default first, so no path can infer a latch.
   always_comb begin
      busy_eff = busy_q;
      if (retire) busy_eff[long_reg_q] = 1'b0;
      for (int i = 0; i < NUM_Q; i++) begin
         query_busy[i] = busy_eff[query_reg[i]];
      end
   end

   // NOTE: state uses non-blocking assignments; the later set below overrides the clear
   // when a new op targets the register that is completing in the same cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy_q     <= '0;
         long_reg_q <= '0;
         long_busy  <= 1'b0;
      end else begin
         if (retire) begin
            busy_q[long_reg_q] <= 1'b0;
            long_busy          <= 1'b0;
         end
         if (set_en) begin
            if (set_reg != REG_BITS'(REG_ZERO)) busy_q[set_reg] <= 1'b1;
            long_reg_q <= set_reg;
            long_busy  <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cpu_hazard_ctrl.sv
// Decode-side hazard detection, bypass selection and long-op scoreboard for the Falcon pipeline.
// Optional macro CPU_HAZARD_STATS_EN adds saturating bubble/stall statistics counters.
module cpu_hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int NUM_SRC    = 2,
   parameter int FWD_STAGES = 2,
   parameter int REG_BITS   = 5,
   parameter int SEL_BITS   = $clog2(FWD_STAGES + 1)
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             stall,
   input  logic                             flush,
   input  logic                             p2_valid,
   input  logic [NUM_SRC-1:0][REG_BITS-1:0] p2_src_reg,
   input  logic [NUM_SRC-1:0]               p2_src_use,
   input  logic [REG_BITS-1:0]              p2_dest_reg,
   input  logic                             p2_write_en,
   input  logic [SEL_BITS-1:0]              p2_avail_stage,
   input  logic                             p2_long,
   input  logic                             long_done,
   output logic [NUM_SRC-1:0][SEL_BITS-1:0] p2_bypass_sel,
   output logic                             p2_bubble,
   output logic                             p2_hold,
   output logic                             long_busy
`ifdef CPU_HAZARD_STATS_EN
   ,
   output logic [31:0]                      stat_data_bubbles,
   output logic [31:0]                      stat_long_stalls
`endif
);

   stage_entry_t                   entry_q [1:FWD_STAGES];
   stage_entry_t                   entry_d;
   logic [NUM_SRC-1:0]             src_hit;
   logic                           data_hazard;
   logic                           sb_hazard;
   logic                           hazard;
   logic                           issue_long;
   logic [NUM_SRC:0][REG_BITS-1:0] sb_query;
   logic [NUM_SRC:0]               sb_busy;

   // Youngest matching stage wins; a match whose result is not ready yet forces a bubble.
   always_comb begin
      src_hit       = '0;
      data_hazard   = 1'b0;
      p2_bypass_sel = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (p2_valid && p2_src_use[i] && (p2_src_reg[i] != REG_BITS'(REG_ZERO))) begin
            for (int k = 1; k <= FWD_STAGES; k++) begin
               if (!src_hit[i] && entry_q[k].write_en &&
                   (entry_q[k].reg_d == STAGE_REG_BITS'(p2_src_reg[i]))) begin
                  src_hit[i] = 1'b1;
                  if (int'(entry_q[k].avail_stage) <= k) p2_bypass_sel[i] = SEL_BITS'(k);
                  else                                   data_hazard      = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) sb_query[i] = p2_src_reg[i];
      sb_query[NUM_SRC] = p2_dest_reg;
   end

   assign sb_hazard = p2_valid &&
                      ((|(sb_busy[NUM_SRC-1:0] & p2_src_use)) ||
                       ((p2_write_en || p2_long) && sb_busy[NUM_SRC]) ||
                       (p2_long && long_busy && !long_done));

   // A flushed instruction is already dead, so it never holds decode.
   assign hazard     = !flush && (data_hazard || sb_hazard);
   assign p2_hold    = hazard;
   assign p2_bubble  = flush || hazard;
   assign issue_long = p2_valid && p2_long && !p2_bubble && !stall;

   cpu_scoreboard #(
      .NUM_Q    (NUM_SRC + 1),
      .REG_BITS (REG_BITS)
   ) u_scoreboard (
      .clock      (clock),
      .reset      (reset),
      .set_en     (issue_long),
      .set_reg    (p2_dest_reg),
      .done       (long_done),
      .query_reg  (sb_query),
      .query_busy (sb_busy),
      .long_busy  (long_busy)
   );

   // Long-op results bypass the forwarding network, so their entry never forwards.
   always_comb begin
      entry_d = nop_entry();
      if (p2_valid && !p2_bubble) begin
         entry_d.reg_d       = STAGE_REG_BITS'(p2_dest_reg);
         entry_d.write_en    = p2_write_en && !p2_long && (p2_dest_reg != REG_BITS'(REG_ZERO));
         entry_d.avail_stage = bypass_sel_t'(p2_avail_stage);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 1; k <= FWD_STAGES; k++) entry_q[k] <= '0;
      end else if (!stall) begin
         entry_q[1] <= entry_d;
         for (int k = 2; k <= FWD_STAGES; k++) entry_q[k] <= entry_q[k-1];
      end
   end

`ifdef CPU_HAZARD_STATS_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_data_bubbles <= '0;
         stat_long_stalls  <= '0;
      end else if (!stall) begin
         if (!flush && data_hazard && (stat_data_bubbles != '1))
            stat_data_bubbles <= stat_data_bubbles + 32'd1;
         if (!flush && sb_hazard && (stat_long_stalls != '1))
            stat_long_stalls <= stat_long_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cpu_hazard_ctrl.sv
// Directed self-checking bench for cpu_hazard_ctrl: bypass, load-use, scoreboard, flush, reset.
// Build with CPU_HAZARD_STATS_EN defined to also cover the statistics counters.
module tb_cpu_hazard_ctrl;
   import cpu_pkg::*;

   logic            clock = 1'b0;
   logic            reset;
   logic            stall;
   logic            flush;
   logic            p2_valid;
   logic [1:0][4:0] p2_src_reg;
   logic [1:0]      p2_src_use;
   logic [4:0]      p2_dest_reg;
   logic            p2_write_en;
   logic [1:0]      p2_avail_stage;
   logic            p2_long;
   logic            long_done;
   logic [1:0][1:0] p2_bypass_sel;
   logic            p2_bubble;
   logic            p2_hold;
   logic            long_busy;
`ifdef CPU_HAZARD_STATS_EN
   logic [31:0]     stat_data_bubbles;
   logic [31:0]     stat_long_stalls;
`endif

   int errors = 0;
   int checks = 0;

   cpu_hazard_ctrl dut (
      .clock          (clock),
      .reset          (reset),
      .stall          (stall),
      .flush          (flush),
      .p2_valid       (p2_valid),
      .p2_src_reg     (p2_src_reg),
      .p2_src_use     (p2_src_use),
      .p2_dest_reg    (p2_dest_reg),
      .p2_write_en    (p2_write_en),
      .p2_avail_stage (p2_avail_stage),
      .p2_long        (p2_long),
      .long_done      (long_done),
      .p2_bypass_sel  (p2_bypass_sel),
      .p2_bubble      (p2_bubble),
      .p2_hold        (p2_hold),
      .long_busy      (long_busy)
`ifdef CPU_HAZARD_STATS_EN
      ,
      .stat_data_bubbles (stat_data_bubbles),
      .stat_long_stalls  (stat_long_stalls)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Packs {sel0, sel1, bubble, hold, long_busy} into one compared word.
   task automatic expect_out(input string tag, input logic [1:0] s0, input logic [1:0] s1,
                             input logic bub, input logic hold, input logic lb);
      #1;
      check(tag, {25'd0, p2_bypass_sel[0], p2_bypass_sel[1], p2_bubble, p2_hold, long_busy},
                 {25'd0, s0, s1, bub, hold, lb});
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      p2_valid       = 1'b0;
      p2_src_reg     = '0;
      p2_src_use     = '0;
      p2_dest_reg    = '0;
      p2_write_en    = 1'b0;
      p2_avail_stage = 2'(AVAIL_ALU);
      p2_long        = 1'b0;
   endtask

   task automatic instr(input logic [4:0] s0, input logic u0, input logic [4:0] s1, input logic u1,
                        input logic [4:0] d, input logic we, input logic [1:0] av, input logic lng);
      p2_valid       = 1'b1;
      p2_src_reg[0]  = s0;
      p2_src_use[0]  = u0;
      p2_src_reg[1]  = s1;
      p2_src_use[1]  = u1;
      p2_dest_reg    = d;
      p2_write_en    = we;
      p2_avail_stage = av;
      p2_long        = lng;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0; long_done = 1'b0;
      idle();
      repeat (2) @(posedge clock);
      #1;
      instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 2'd1, 1'b0);
      expect_out("reset_state", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      idle();
      reset = 1'b0;
      tick();

      // ALU producer r5, consumer walks through stage 1, stage 2, then register file
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'd1, 1'b0); tick();
      instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0);
      expect_out("alu_fwd_s1", 2'd1, 2'd0, 1'b0, 1'b0, 1'b0); tick();
      expect_out("alu_fwd_s2", 2'd2, 2'd0, 1'b0, 1'b0, 1'b0); tick();
      expect_out("alu_rf_a",   2'd0, 2'd0, 1'b0, 1'b0, 1'b0); tick();
      expect_out("alu_rf_b",   2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

      // stall holds the stage entries in place
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 2'd1, 1'b0); tick();
      instr(5'd0, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 2'd1, 1'b0);
      stall = 1'b1;
      expect_out("stall_s1_a", 2'd0, 2'd1, 1'b0, 1'b0, 1'b0); tick();
      expect_out("stall_s1_b", 2'd0, 2'd1, 1'b0, 1'b0, 1'b0);
      stall = 1'b0; tick();
      expect_out("stall_rel_s2", 2'd0, 2'd2, 1'b0, 1'b0, 1'b0);
      idle(); tick(); tick();

      // load-use: exactly one bubble, then forward from stage 2
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'(AVAIL_LOAD), 1'b0); tick();
      instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0);
      expect_out("load_use_bubble", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0); tick();
      expect_out("load_use_after",  2'd2, 2'd0, 1'b0, 1'b0, 1'b0); tick();
      idle(); tick(); tick();

      // load with an independent instruction between: no bubble
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 2'(AVAIL_LOAD), 1'b0); tick();
      instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 2'd1, 1'b0); tick();
      instr(5'd0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 2'd1, 1'b0);
      expect_out("load_gap_s2", 2'd0, 2'd2, 1'b0, 1'b0, 1'b0);
      idle(); tick(); tick();

      // two producers of r3: youngest wins for both operands
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'd1, 1'b0); tick();
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'd1, 1'b0); tick();
      instr(5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 2'd1, 1'b0);
      expect_out("youngest_wins", 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
      idle(); tick(); tick();

      // divide r9: consumer stalls until long_done, then reads the register file
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'd1, 1'b1);
      expect_out("div_issue", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0); tick();
      instr(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0);
      expect_out("div_raw_a", 2'd0, 2'd0, 1'b1, 1'b1, 1'b1); tick();
      expect_out("div_raw_b", 2'd0, 2'd0, 1'b1, 1'b1, 1'b1);
      p2_src_use[0] = 1'b0;
      expect_out("div_unused_src", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      p2_src_use[0] = 1'b1;
      long_done = 1'b1;
      expect_out("div_done_same", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1); tick();
      long_done = 1'b0;
      expect_out("div_after_done", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

      // WAW and a second divide while busy; a divide in the long_done cycle proceeds
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 2'd1, 1'b1); tick();
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 2'd1, 1'b0);
      expect_out("waw_stall", 2'd0, 2'd0, 1'b1, 1'b1, 1'b1);
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 2'd1, 1'b1);
      expect_out("div2_busy", 2'd0, 2'd0, 1'b1, 1'b1, 1'b1); tick();
      long_done = 1'b1;
      expect_out("div2_on_done", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1); tick();
      long_done = 1'b0;
      instr(5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0);
      expect_out("r10_cleared", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      instr(5'd0, 1'b0, 5'd11, 1'b1, 5'd0, 1'b0, 2'd1, 1'b0);
      expect_out("r11_busy", 2'd0, 2'd0, 1'b1, 1'b1, 1'b1);
      idle(); long_done = 1'b1; tick();
      long_done = 1'b0;
      expect_out("div2_retired", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

      // flush: bubble without hold, killed load leaves no trace in stage 1
      flush = 1'b1;
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 2'(AVAIL_LOAD), 1'b0);
      expect_out("flush_load", 2'd0, 2'd0, 1'b1, 1'b0, 1'b0); tick();
      flush = 1'b0;
      instr(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0);
      expect_out("flush_nop_s1", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0); tick();

      // flushed divide must not set the scoreboard
      flush = 1'b1;
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 2'd1, 1'b1); tick();
      flush = 1'b0; idle();
      expect_out("flush_div_noset", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

      // in-flight divide survives a flush
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 2'd1, 1'b1); tick();
      idle(); flush = 1'b1;
      expect_out("flush_inflight", 2'd0, 2'd0, 1'b1, 1'b0, 1'b1); tick();
      flush = 1'b0;
      expect_out("inflight_kept", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      long_done = 1'b1; tick();
      long_done = 1'b0;

      // r0 never forwards or hazards
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'(AVAIL_LOAD), 1'b0); tick();
      instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 2'd1, 1'b0);
      expect_out("r0_no_fwd", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      idle(); tick(); tick();

      // invalid p2 raises no hazard
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 2'(AVAIL_LOAD), 1'b0); tick();
      instr(5'd14, 1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 2'd1, 1'b0);
      p2_valid = 1'b0;
      expect_out("invalid_no_haz", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      idle(); tick(); tick();

      // reset in the middle of a long op
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd15, 1'b1, 2'd1, 1'b1); tick();
      instr(5'd15, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0);
      expect_out("pre_reset_busy", 2'd0, 2'd0, 1'b1, 1'b1, 1'b1);
      reset = 1'b1;
      expect_out("reset_mid_long", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
`ifdef CPU_HAZARD_STATS_EN
      check("stat_bubbles_rst", stat_data_bubbles, 32'd0);
      check("stat_stalls_rst",  stat_long_stalls,  32'd0);
`endif
      tick();
      reset = 1'b0; idle(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
